instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Single-outstanding instruction prefetcher with redirect flush.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit #(
  parameter int                   ADDR_SIZE = 12,
  parameter int                   IR_SIZE   = 32,
  parameter int                   DEPTH     = 4,
  parameter logic [ADDR_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ADDR_SIZE-1:0] mem_addr,
  input  logic                 mem_rsp_valid,
  input  logic [IR_SIZE-1:0]   mem_rsp_data,
  input  logic                 redirect_valid,
  input  logic [ADDR_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  output logic                 ir_valid,
  input  logic                 ir_ready,
  output logic [IR_SIZE-1:0]   ir,
  output logic [ADDR_SIZE-1:0] ir_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [ADDR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_SIZE-1:0] issued_q, issued_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [IR_SIZE-1:0]   fifo_ir_q [DEPTH];
  logic [ADDR_SIZE-1:0] fifo_pc_q [DEPTH];

  logic w_req_fire;
  logic w_push;
  logic w_pop;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. A response always closes the outstanding request,
  // whether it is kept or discarded.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ:  if (w_req_fire) state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_rsp_valid)       state_d = ST_REQ;
        else if (redirect_valid) state_d = ST_DROP;
      end
      ST_DROP: if (mem_rsp_valid) state_d = ST_REQ;
      default: state_d = ST_REQ;
    endcase
  end

  // FSM: outputs and handshake qualifiers
  always_comb begin
    mem_req_valid = 1'b0;
    w_push        = 1'b0;
    if (state_q == ST_REQ) begin
      mem_req_valid = !rst && !halt && !redirect_valid && (count_q < C_DEPTH);
    end
    if (state_q == ST_WAIT) begin
      w_push = mem_rsp_valid && !redirect_valid;
    end
  end

  assign w_req_fire = mem_req_valid && mem_req_ready;
  assign w_pop      = ir_valid && ir_ready && !redirect_valid;
  assign mem_addr   = fetch_pc_q;
  assign ir_valid   = (count_q != '0);
  assign ir         = fifo_ir_q[rd_ptr_q];
  assign ir_pc      = fifo_pc_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    issued_d   = issued_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (w_req_fire) begin
        fetch_pc_d = fetch_pc_q + ADDR_SIZE'(1);
        issued_d   = fetch_pc_q;
      end
      if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (w_push && !w_pop)      count_d = count_q + CNT_W'(1);
      else if (!w_push && w_pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      issued_q   <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_ir_q[i] <= '0;
        fifo_pc_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      issued_q   <= issued_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (w_push) begin
        fifo_ir_q[wr_ptr_q] <= mem_rsp_data;
        fifo_pc_q[wr_ptr_q] <= issued_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Randomized scoreboard bench for instr_fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_unit;

  localparam int          AW  = 12;
  localparam int          DW  = 32;
  localparam int          D   = 4;
  localparam logic [11:0] RPC = 12'hFFE;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rsp_valid = 1'b0;
  logic [DW-1:0] mem_rsp_data = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          halt = 1'b0;
  logic          ir_valid;
  logic          ir_ready = 1'b0;
  logic [DW-1:0] ir;
  logic [AW-1:0] ir_pc;

  int vectors = 0;
  int errors  = 0;
  ent_t expq[$];

  // stimulus knobs (percent, except p_rst which is per mille)
  int p_ready = 100, lat_min = 1, lat_max = 1, p_irr = 100;
  int p_redir = 0, p_halt = 0, p_rst = 0, mode = 0;
  int halt_cnt = 0, lat_cnt = 0;
  logic hit = 1'b0, pre = 1'b0, pend = 1'b0;
  logic [AW-1:0] pend_addr = '0;

  instr_fetch_unit #(
    .ADDR_SIZE(AW), .IR_SIZE(DW), .DEPTH(D), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, 20'h5A5A5} ^ (32'(a) * 32'h9E3779B1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus plus the memory responder.
  task automatic step();
    logic rsp;
    @(posedge clk); #1;
    rsp = 1'b0;
    if (pend) begin
      lat_cnt--;
      if (lat_cnt == 0) begin rsp = 1'b1; pend = 1'b0; end
    end
    mem_rsp_valid  = rsp;
    mem_rsp_data   = rsp ? mem_word(pend_addr) : 32'($urandom);
    mem_req_ready  = ($urandom_range(99) < p_ready);
    ir_ready       = ($urandom_range(99) < p_irr);
    redirect_valid = ($urandom_range(99) < p_redir);
    redirect_pc    = AW'($urandom);
    halt           = ($urandom_range(99) < p_halt) || (halt_cnt > 0);
    if (halt_cnt > 0) halt_cnt--;
    rst            = ($urandom_range(999) < p_rst);
    case (mode)
      1: begin
        if (!pre) begin
          redirect_valid = 1'b1; redirect_pc = 12'h002; pre = 1'b1;
        end else if (!hit && pend && pend_addr == 12'h005) begin
          redirect_valid = 1'b1; redirect_pc = 12'h100; hit = 1'b1;
        end
      end
      2: if (!hit && rsp && ir_valid) begin
        redirect_valid = 1'b1; ir_ready = 1'b1; redirect_pc = 12'h3C0; hit = 1'b1;
      end
      3: if (!hit && pend) begin
        halt = 1'b1; halt_cnt = 8; hit = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pend = 1'b0; mem_rsp_valid = 1'b0;
    end
    @(negedge clk);
    if (!rst && mem_req_valid && mem_req_ready) begin
      pend      = 1'b1;
      lat_cnt   = $urandom_range(lat_max, lat_min);
      pend_addr = mem_addr;
    end
  endtask

  // Reference model: a kept fetch is one whose response arrives with no
  // redirect (or reset) between its acceptance and its response.
  initial begin : model
    logic          outst, stale, do_push, do_clear, exp_req;
    logic [AW-1:0] exp_pc, out_addr;
    ent_t          e;
    outst = 1'b0; stale = 1'b0; exp_pc = RPC; out_addr = '0;
    forever begin
      @(negedge clk);
      do_push = 1'b0; do_clear = 1'b0;
      if (rst) begin
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_ir_valid", 64'(ir_valid), 64'd0);
        chk("rst_ir", 64'(ir), 64'd0);
        chk("rst_ir_pc", 64'(ir_pc), 64'd0);
        outst = 1'b0; stale = 1'b0; exp_pc = RPC; do_clear = 1'b1;
      end else begin
        exp_req = !outst && !halt && !redirect_valid && (expq.size() < D);
        chk("req_valid", 64'(mem_req_valid), 64'(exp_req));
        chk("ir_valid", 64'(ir_valid), 64'(expq.size() != 0));
        if (mem_req_valid && mem_req_ready) begin
          chk("mem_addr", 64'(mem_addr), 64'(exp_pc));
          outst = 1'b1; stale = 1'b0; out_addr = exp_pc; exp_pc = exp_pc + 1'b1;
        end
        if (mem_rsp_valid) begin
          if (outst && !stale && !redirect_valid) do_push = 1'b1;
          outst = 1'b0; stale = 1'b0;
        end
        if (redirect_valid) begin
          if (outst) stale = 1'b1;
          exp_pc = redirect_pc; do_clear = 1'b1;
        end
      end
      #2;
      if (do_clear) expq.delete();
      else if (do_push) begin
        e.pc = out_addr; e.data = mem_word(out_addr);
        expq.push_back(e);
      end
    end
  end

  initial begin : monitor
    ent_t e;
    forever begin
      @(negedge clk); #1;
      if (!rst && ir_valid && ir_ready && !redirect_valid) begin
        if (expq.size() == 0) begin
          vectors++; errors++;
          $display("FAIL pop_unexpected: got ir_pc %0h, expected no instruction", ir_pc);
        end else begin
          e = expq.pop_front();
          chk("ir_pc", 64'(ir_pc), 64'(e.pc));
          chk("ir", 64'(ir), 64'(e.data));
        end
      end
    end
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    // streaming from RESET_PC across the address wrap
    repeat (30) step();
    // fill the prefetch buffer, then drain
    p_irr = 0;   repeat (25) step();
    p_irr = 100; repeat (25) step();
    // redirect while waiting on address 5
    mode = 1; lat_min = 3; lat_max = 3; hit = 1'b0; pre = 1'b0;
    for (int i = 0; i < 80 && !hit; i++) step();
    chk("dir_redirect_wait5", 64'(hit), 64'd1);
    mode = 0; repeat (20) step();
    // redirect coinciding with a response and a pop
    mode = 2; lat_min = 1; lat_max = 1; p_irr = 50; hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) step();
    chk("dir_redirect_rsp_pop", 64'(hit), 64'd1);
    mode = 0; p_irr = 100; repeat (20) step();
    // halt while a request is outstanding
    mode = 3; lat_min = 2; lat_max = 4; hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) step();
    chk("dir_halt_wait", 64'(hit), 64'd1);
    mode = 0; repeat (20) step();
    // random mix including resets mid-request
    p_ready = 60; lat_min = 1; lat_max = 4; p_irr = 60;
    p_redir = 4; p_halt = 10; p_rst = 3;
    repeat (3000) step();
    p_ready = 100; p_irr = 100; p_redir = 0; p_halt = 0; p_rst = 0;
    repeat (30) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
